score_display: RTL and testbench
================================

# score_display

Upstream feeder of the pixel colour stage: maintains the running game score as a BCD counter advanced once per N frames, and drives the per-pixel `o_color_score` flag for a seven-segment rendering of that score at a fixed screen position. The flag is a zero-latency combinational function of the incoming beam position, so it lines up with the colour stage's own one-cycle register. The block also exports the raw BCD score to game logic.

## Interface

Parameters:
- `CONV`, 0: position LSB dropped by the timing generator; position ports are `[9:CONV]`.
- `DIGITS`, 4: number of BCD digits, 1..6.
- `FRAMES_PER_POINT`, 6: frames per +1 score, 1..63.
- `X0`, 8: left edge of digit 0 (most significant), in position-port units.
- `Y0`, 8: top edge of all digits, in position-port units.

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `i_hpos` in `[9:CONV]`: current beam column.
- `i_vpos` in `[9:CONV]`: current beam row.
- `i_vsync` in 1: active-high vertical sync.
- `i_run` in 1: game running; scoring is enabled only while this is high.
- `i_clear` in 1: synchronous score clear.
- `o_color_score` out 1: current pixel belongs to a lit segment.
- `o_score` out `4*DIGITS`: live BCD score; digit 0 is the MSBs.
- `o_max` out 1: score saturated at all nines.

## Operation

- **Frame tick**
  - `vs_q` registers `i_vsync`.
  - `tick = i_vsync & ~vs_q`, a one-cycle pulse on each vsync rising edge.
- **Prescaler**
  - 6-bit `pre`. On a tick with `i_run` high: if `pre == FRAMES_PER_POINT-1`, then `pre <= 0` and the block increments the score; otherwise `pre <= pre+1`.
  - `pre` holds when `i_run` is low.
- **BCD counter**
  - Ripple increment from the least significant digit. A digit at 9 goes to 0 and carries.
  - At all nines the increment is suppressed. The score holds, and `o_max` = 1 combinationally from the score.
- **Clear**
  - When `i_clear` = 1: score, `pre` and `snap` go to 0 on the next edge.
  - Clear has priority over a simultaneous tick.
  - `shown` is unaffected.
- **Snapshot**
  - On each tick, `snap <= score`, taking the score value before this cycle's update.
  - Rendering uses `snap` only, so the digits never change mid-frame. A point earned on tick k is displayed from tick k+1.
- **Shown flag**
  - Cleared by reset, set on the first tick.
  - `o_color_score` is forced to 0 while `shown` = 0, so there is no garbage before the first full frame.
- **Rendering** (combinational)
  - Digit cell i spans x in [X0+12i, X0+12i+8) and y in [Y0, Y0+14). The 4-column gap between cells is unlit.
  - Local coordinates are lx = x − cell left and ly = y − Y0. Find the cell by per-digit range compares; no division.
  - Segments, all 2 px thick:
    - a: ly 0–1
    - g: ly 6–7
    - d: ly 12–13
    - f: lx 0–1, ly 0–7
    - b: lx 6–7, ly 0–7
    - e: lx 0–1, ly 6–13
    - c: lx 6–7, ly 6–13
  - Standard 7-seg decode (1 = b,c; 7 = a,b,c; etc.). Digit codes 10–15 never occur and render blank.
  - `o_color_score` = `shown` & inside a cell & lit segment.
- **Arithmetic**
  - Compare in 11-bit unsigned, with positions zero-extended, to avoid wrap at the screen edge.
  - A cell extending past 1023 is simply clipped.

## Timing

- **Reset values:** `o_color_score` 0, `o_score` 0, `o_max` 0; internally `pre`, `snap`, `vs_q` and `shown` are 0.
- **`o_color_score` latency:** 0 cycles from `i_hpos`/`i_vpos`, and a function of registered `snap`/`shown` only.
- **Score update:** `o_score` updates on the clock edge at which `tick` is high, i.e. 1 cycle after the `i_vsync` rise.
- **`i_vsync` held high:** only one tick is produced.
- **Reset mid-frame:** output is blank until the next vsync rising edge; score is 0.
- **`i_run` dropping mid-prescale:** `pre` is retained and resumes when `i_run` returns.

## Structure

- **Shared package `dino_pkg`:**
  - `DIGIT_W` = 8, `DIGIT_H` = 14, `DIGIT_PITCH` = 12, `SEG_T` = 2.
  - The 7-bit segment decode constants for 0–9.
- **Sub-module `seg7_pixel`:** inputs are the 4-bit digit, lx[2:0] and ly[3:0]; output is 1-bit lit. It is instantiated `DIGITS` times via generate.

## Test plan

- **Reset then first frame:** apply reset; sweep the full raster before any vsync → `o_color_score` never 1. After one vsync pulse, pixel (X0, Y0) = 1 (segment a of "0") and pixel (X0+3, Y0+6) = 0 (g unlit for 0).
- **Prescale:** `i_run` = 1, `FRAMES_PER_POINT` = 6; give 12 vsync pulses → `o_score` = 0x0002. `i_run` = 0 for 5 pulses → the score stays at 0x0002.
- **Carry/saturation:** preload by running to 0x0099; one more point → 0x0100. Force a run to 0x9999 → `o_max` = 1, and further ticks hold 0x9999.
- **Clear vs tick:** assert `i_clear` in the same cycle as `tick` with `pre` at terminal count → next cycle `o_score` = 0 and `pre` = 0.
- **Snapshot tearing:** a score change at tick k → the rendered digit at (X0+36+6, Y0+2) changes only in the frame after tick k+1, with no change mid-frame.
- **Geometry:** with `snap` = 0x1888, scan row Y0+7 → lit columns exactly match the expected g-segment plus left/right verticals, and gap columns X0+8..X0+11 = 0.

Source files
------------

// File: rtl/dino_pkg.sv
// Shared constants for the dino game renderers: seven-segment glyph geometry
// and the BCD-to-segment decode used by the score display.
package dino_pkg;

  localparam int DIGIT_W     = 8;
  localparam int DIGIT_H     = 14;
  localparam int DIGIT_PITCH = 12;
  localparam int SEG_T       = 2;

  // Segment bit order, MSB first: a b c d e f g
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
    logic [6:0] segs;
    case (digit)
      4'd0:    segs = SEG_0;
      4'd1:    segs = SEG_1;
      4'd2:    segs = SEG_2;
      4'd3:    segs = SEG_3;
      4'd4:    segs = SEG_4;
      4'd5:    segs = SEG_5;
      4'd6:    segs = SEG_6;
      4'd7:    segs = SEG_7;
      4'd8:    segs = SEG_8;
      4'd9:    segs = SEG_9;
      default: segs = 7'b0000000;
    endcase
    return segs;
  endfunction

endpackage

// File: rtl/seg7_pixel.sv
// Decides whether one pixel inside an 8x14 digit cell falls on a lit segment.
module seg7_pixel
  import dino_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic [2:0] i_lx,
  input  logic [3:0] i_ly,
  output logic       o_lit
);

  logic [6:0] segs;
  logic       col_l, col_r, row_top, row_mid, row_bot, half_up, half_lo;

  always_comb begin
    segs    = seg7_decode(i_digit);
    col_l   = (i_lx < 3'(SEG_T));
    col_r   = (i_lx >= 3'(DIGIT_W - SEG_T));
    row_top = (i_ly < 4'(SEG_T));
    row_mid = (i_ly >= 4'(DIGIT_H/2 - 1)) && (i_ly < 4'(DIGIT_H/2 + 1));
    row_bot = (i_ly >= 4'(DIGIT_H - SEG_T));
    // Verticals overlap the middle bar so the upper and lower halves join.
    half_up = (i_ly < 4'(DIGIT_H/2 + 1));
    half_lo = (i_ly >= 4'(DIGIT_H/2 - 1));
    o_lit   = (segs[6] & row_top)
            | (segs[5] & col_r & half_up)
            | (segs[4] & col_r & half_lo)
            | (segs[3] & row_bot)
            | (segs[2] & col_l & half_lo)
            | (segs[1] & col_l & half_up)
            | (segs[0] & row_mid);
  end

endmodule

// File: rtl/score_display.sv
// BCD game score advanced every FRAMES_PER_POINT frames, rendered as
// seven-segment digits from a per-frame snapshot so digits never tear.
module score_display
  import dino_pkg::*;
#(
  parameter int CONV             = 0,
  parameter int DIGITS           = 4,
  parameter int FRAMES_PER_POINT = 6,
  parameter int X0               = 8,
  parameter int Y0               = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:CONV]         i_hpos,
  input  logic [9:CONV]         i_vpos,
  input  logic                  i_vsync,
  input  logic                  i_run,
  input  logic                  i_clear,
  output logic                  o_color_score,
  output logic [4*DIGITS-1:0]   o_score,
  output logic                  o_max
);

  localparam int          SW     = 4*DIGITS;
  localparam logic [10:0] CELL_Y = 11'(Y0);
  localparam logic [5:0]  PRE_TC = 6'(FRAMES_PER_POINT - 1);

  logic          vs_q, vs_d;
  logic [5:0]    pre_q, pre_d;
  logic [SW-1:0] score_q, score_d, snap_q, snap_d, score_inc;
  logic          shown_q, shown_d;
  logic          tick, at_max, carry;
  logic [10:0]   x_ext, y_ext;
  logic [DIGITS-1:0] hit;

  // Ripple BCD increment from the least significant nibble.
  always_comb begin
    score_inc = score_q;
    carry     = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (carry) begin
        if (score_q[4*j +: 4] == 4'd9) begin
          score_inc[4*j +: 4] = 4'd0;
          carry               = 1'b1;
        end else begin
          score_inc[4*j +: 4] = score_q[4*j +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end else begin
        carry = 1'b0;
      end
    end
  end

  assign at_max = (score_q == {DIGITS{4'h9}});
  assign tick   = i_vsync & ~vs_q;

  always_comb begin
    vs_d    = i_vsync;
    pre_d   = pre_q;
    score_d = score_q;
    snap_d  = snap_q;
    shown_d = shown_q | tick;
    // Clear wins over a coincident tick.
    if (i_clear) begin
      pre_d   = 6'd0;
      score_d = '0;
      snap_d  = '0;
    end else if (tick) begin
      snap_d = score_q;
      if (i_run) begin
        if (pre_q == PRE_TC) begin
          pre_d   = 6'd0;
          score_d = at_max ? score_q : score_inc;
        end else begin
          pre_d = pre_q + 6'd1;
        end
      end else begin
        pre_d = pre_q;
      end
    end else begin
      snap_d = snap_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_q    <= 1'b0;
      pre_q   <= 6'd0;
      score_q <= '0;
      snap_q  <= '0;
      shown_q <= 1'b0;
    end else begin
      vs_q    <= vs_d;
      pre_q   <= pre_d;
      score_q <= score_d;
      snap_q  <= snap_d;
      shown_q <= shown_d;
    end
  end

  // 11-bit math keeps cells near the right/bottom edge from wrapping to 0.
  assign x_ext = 11'(i_hpos);
  assign y_ext = 11'(i_vpos);

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    localparam logic [10:0] CELL_X = 11'(X0 + DIGIT_PITCH*g);
    logic [10:0] dx, dy;
    logic        in_cell, lit;

    assign dx      = x_ext - CELL_X;
    assign dy      = y_ext - CELL_Y;
    assign in_cell = (x_ext >= CELL_X) && (dx < 11'(DIGIT_W))
                  && (y_ext >= CELL_Y) && (dy < 11'(DIGIT_H));

    seg7_pixel u_seg (
      .i_digit (snap_q[4*(DIGITS-1-g) +: 4]),
      .i_lx    (dx[2:0]),
      .i_ly    (dy[3:0]),
      .o_lit   (lit)
    );

    assign hit[g] = in_cell & lit;
  end

  assign o_color_score = shown_q & (|hit);
  assign o_score       = score_q;
  assign o_max         = at_max;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: a default instance (6 frames/point) and a
// fast instance (1 frame/point) used for long carry/saturation/geometry runs.
module tb_score_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hpos, vpos;
  logic        vs1, run1, clr1, vs2, run2, clr2;
  logic        cs1, cs2, max1, max2;
  logic [15:0] sc1, sc2;
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  int          lit_cnt;
  logic        exp_lit;

  always #5 clk = ~clk;

  score_display u_dut (
    .clk(clk), .reset(reset), .i_hpos(hpos), .i_vpos(vpos),
    .i_vsync(vs1), .i_run(run1), .i_clear(clr1),
    .o_color_score(cs1), .o_score(sc1), .o_max(max1)
  );

  score_display #(.FRAMES_PER_POINT(1)) u_fast (
    .clk(clk), .reset(reset), .i_hpos(hpos), .i_vpos(vpos),
    .i_vsync(vs2), .i_run(run2), .i_clear(clr2),
    .o_color_score(cs2), .o_score(sc2), .o_max(max2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic exp, input bit fast);
    hpos = 10'(x);
    vpos = 10'(y);
    #1;
    chk(tag, fast ? {31'd0, cs2} : {31'd0, cs1}, {31'd0, exp});
  endtask

  task automatic pulse(input int n, input bit fast);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (fast) vs2 = 1'b1; else vs1 = 1'b1;
      @(negedge clk);
      vs1 = 1'b0;
      vs2 = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    hpos = 10'd0; vpos = 10'd0;
    vs1 = 1'b0; run1 = 1'b0; clr1 = 1'b0;
    vs2 = 1'b0; run2 = 1'b0; clr2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_score", sc1, 32'h0);
    chk("reset_max", max1, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Nothing may be drawn before the first vsync.
    lit_cnt = 0;
    for (int y = 0; y < 40; y++) begin
      for (int x = 0; x < 100; x++) begin
        hpos = 10'(x); vpos = 10'(y); #1;
        if (cs1 !== 1'b0) lit_cnt++;
      end
    end
    chk("blank_before_vsync", lit_cnt, 32'd0);

    pulse(1, 1'b0);
    pix("zero_seg_a", 8, 8, 1'b1, 1'b0);
    pix("zero_seg_g_off", 11, 14, 1'b0, 1'b0);
    chk("score_after_idle_tick", sc1, 32'h0);

    run1 = 1'b1;
    pulse(6, 1'b0);
    chk("prescale_6", sc1, 32'h0001);
    pulse(6, 1'b0);
    chk("prescale_12", sc1, 32'h0002);
    run1 = 1'b0;
    pulse(5, 1'b0);
    chk("run_low_hold", sc1, 32'h0002);

    // Score 2 -> 5 over 18 ticks; tick 18 is the change tick k.
    run1 = 1'b1;
    pulse(17, 1'b0);
    chk("score_before_k", sc1, 32'h0004);
    pulse(1, 1'b0);
    chk("score_at_k", sc1, 32'h0005);
    pix("snap_old_after_k", 50, 10, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    pix("snap_old_midframe", 50, 10, 1'b1, 1'b0);
    run1 = 1'b0;
    pulse(1, 1'b0);
    pix("snap_new_after_k1", 50, 10, 1'b0, 1'b0);

    // Clear coincident with a terminal-count tick.
    run1 = 1'b1;
    pulse(5, 1'b0);
    chk("pre_tc_score", sc1, 32'h0005);
    @(negedge clk);
    clr1 = 1'b1; vs1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0; vs1 = 1'b0;
    chk("clear_beats_tick", sc1, 32'h0);
    pix("shown_kept_on_clear", 8, 8, 1'b1, 1'b0);
    pulse(5, 1'b0);
    chk("post_clear_5", sc1, 32'h0);
    pulse(1, 1'b0);
    chk("post_clear_6", sc1, 32'h0001);

    // Clear alone mid-prescale must zero the prescaler.
    pulse(3, 1'b0);
    @(negedge clk);
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    chk("clear_alone", sc1, 32'h0);
    pulse(5, 1'b0);
    chk("pre_zeroed_by_clear", sc1, 32'h0);

    // Reset mid-frame blanks the display until the next vsync rise.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_score", sc1, 32'h0);
    pix("midreset_blank", 8, 8, 1'b0, 1'b0);
    run1 = 1'b0;
    pulse(1, 1'b0);
    pix("midreset_shown", 8, 8, 1'b1, 1'b0);

    // Fast instance: carry, geometry, saturation.
    run2 = 1'b1;
    pulse(99, 1'b1);
    chk("fast_0099", sc2, 32'h0099);
    pulse(1, 1'b1);
    chk("fast_carry_0100", sc2, 32'h0100);
    pulse(1788, 1'b1);
    chk("fast_1888", sc2, 32'h1888);
    run2 = 1'b0;
    pulse(1, 1'b1);
    for (int x = 0; x < 64; x++) begin
      if (x >= 8 && x < 16)
        exp_lit = ((x - 8) >= 6);
      else if (x >= 20 && x < 52)
        exp_lit = (((x - 20) % 12) < 8);
      else
        exp_lit = 1'b0;
      pix($sformatf("row7_x%0d", x), x, 15, exp_lit, 1'b1);
    end
    run2 = 1'b1;
    pulse(8110, 1'b1);
    chk("fast_9998", sc2, 32'h9998);
    chk("max_low_9998", max2, 32'h0);
    pulse(1, 1'b1);
    chk("fast_9999", sc2, 32'h9999);
    chk("max_high", max2, 32'h1);
    pulse(3, 1'b1);
    chk("saturate_hold", sc2, 32'h9999);
    chk("max_hold", max2, 32'h1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
